// File: rtl/pes_vm_multi.sv
// Multi-item vending controller: accumulates coin credit, vends priced items and
// pays change or refunds one coin per cycle, largest denomination first.
module pes_vm_multi #(
    parameter int unsigned NUM_ITEMS  = 4,
    parameter int unsigned CREDIT_W   = 7,
    parameter int unsigned MAX_CREDIT = 95,
    parameter int unsigned COIN1_VAL  = 5,
    parameter int unsigned COIN2_VAL  = 10,
    parameter int unsigned COIN3_VAL  = 25,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {7'd50, 7'd30, 7'd20, 7'd15},
    localparam int unsigned IDX_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic                sel_valid,
    input  logic [IDX_W-1:0]    sel,
    input  logic                cancel,
    output logic                vend,
    output logic [IDX_W-1:0]    vend_item,
    output logic                change_valid,
    output logic [1:0]          change_coin,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                coin_reject,
    output logic                sel_denied
);

    localparam int unsigned SUM_W = CREDIT_W + 1;

    // Denominations must be strictly ordered and every amount a multiple of the
    // smallest coin, otherwise the greedy change loop could not reach zero.
    if (!(COIN1_VAL < COIN2_VAL && COIN2_VAL < COIN3_VAL && COIN3_VAL <= MAX_CREDIT &&
          MAX_CREDIT < (32'd1 << CREDIT_W) && (MAX_CREDIT % COIN1_VAL) == 0)) begin : g_bad_coins
        $error("pes_vm_multi: inconsistent coin/credit parameters");
    end
    for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_price_chk
        if ((32'(PRICES[g*CREDIT_W +: CREDIT_W]) % COIN1_VAL) != 0) begin : g_bad_price
            $error("pes_vm_multi: price not a multiple of the smallest coin");
        end
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_VEND   = 2'd2,
        S_CHANGE = 2'd3
    } state_t;

    function automatic logic [SUM_W-1:0] coin_value(input logic [1:0] code);
        case (code)
            2'd1:    return SUM_W'(COIN1_VAL);
            2'd2:    return SUM_W'(COIN2_VAL);
            2'd3:    return SUM_W'(COIN3_VAL);
            default: return '0;
        endcase
    endfunction

    function automatic logic [CREDIT_W-1:0] price_of(input logic [IDX_W-1:0] idx);
        logic [CREDIT_W-1:0] p;
        p = '0;
        for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
            if (32'(idx) == i) p = PRICES[i*CREDIT_W +: CREDIT_W];
        end
        return p;
    endfunction

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_d;
    logic                vend_d, change_valid_d, busy_d, coin_reject_d, sel_denied_d;
    logic [IDX_W-1:0]    vend_item_d;
    logic [1:0]          change_coin_d;

    // Coin acceptance, selection and change-coin decode shared by both comb blocks
    logic                accepting, coin_take, coin_fits, sel_req, sel_ok, sel_grant, refund_go;
    logic [SUM_W-1:0]    coin_sum;
    logic [CREDIT_W-1:0] credit_in, price, chg_src, chg_val;
    logic [1:0]          chg_code;

    assign accepting = (state_q == S_IDLE) || (state_q == S_CREDIT);
    assign coin_sum  = {1'b0, credit} + coin_value(coin);
    assign coin_fits = coin_sum <= SUM_W'(MAX_CREDIT);
    assign coin_take = accepting && (coin != 2'd0) && coin_fits;
    assign credit_in = coin_take ? CREDIT_W'(coin_sum) : credit;

    assign price     = price_of(sel);
    assign sel_ok    = 32'(sel) < NUM_ITEMS;
    assign sel_req   = accepting && sel_valid && !cancel;
    assign sel_grant = sel_req && sel_ok && (credit >= price);
    assign refund_go = (state_q == S_CREDIT) && cancel;

    // A refund also pays back a coin accepted in the same cycle
    assign chg_src  = accepting ? credit_in : credit;
    assign chg_code = (32'(chg_src) >= COIN3_VAL) ? 2'd3 :
                      (32'(chg_src) >= COIN2_VAL) ? 2'd2 :
                      (32'(chg_src) >= COIN1_VAL) ? 2'd1 : 2'd0;
    assign chg_val  = CREDIT_W'(coin_value(chg_code));

    // State and registered-output register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            credit       <= '0;
            vend         <= 1'b0;
            vend_item    <= '0;
            change_valid <= 1'b0;
            change_coin  <= 2'd0;
            busy         <= 1'b0;
            coin_reject  <= 1'b0;
            sel_denied   <= 1'b0;
        end else begin
            state_q      <= state_d;
            credit       <= credit_d;
            vend         <= vend_d;
            vend_item    <= vend_item_d;
            change_valid <= change_valid_d;
            change_coin  <= change_coin_d;
            busy         <= busy_d;
            coin_reject  <= coin_reject_d;
            sel_denied   <= sel_denied_d;
        end
    end

    // Next state and next credit
    always_comb begin
        state_d  = state_q;
        credit_d = credit;
        unique case (state_q)
            S_IDLE, S_CREDIT: begin
                if (refund_go) begin
                    state_d  = S_CHANGE;
                    credit_d = chg_src - chg_val;
                end else if (sel_grant) begin
                    state_d  = S_VEND;
                    credit_d = credit_in - price;
                end else begin
                    state_d  = (credit_in != '0) ? S_CREDIT : S_IDLE;
                    credit_d = credit_in;
                end
            end
            S_VEND: begin
                if (credit != '0) begin
                    state_d  = S_CHANGE;
                    credit_d = chg_src - chg_val;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CHANGE: begin
                if (credit != '0) begin
                    credit_d = credit - chg_val;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                credit_d = '0;
            end
        endcase
    end

    // Next values of the registered outputs; a CHANGE cycle always carries a coin
    always_comb begin
        vend_d         = sel_grant;
        vend_item_d    = sel_grant ? sel : '0;
        change_valid_d = (state_d == S_CHANGE);
        change_coin_d  = (state_d == S_CHANGE) ? chg_code : 2'd0;
        busy_d         = (state_d == S_VEND) || (state_d == S_CHANGE);
        coin_reject_d  = (coin != 2'd0) && !coin_take;
        sel_denied_d   = sel_req && !sel_grant;
    end

endmodule

// File: tb/tb_pes_vm_multi.sv
// Scoreboard bench for pes_vm_multi: default 4-item build plus a 3-item build
// used for the out-of-range selection case.
module tb_pes_vm_multi;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic [1:0] coin, sel, d3_coin, d3_sel;
    logic       sel_valid, cancel, d3_sel_valid, d3_cancel;
    logic       vend, change_valid, busy, coin_reject, sel_denied;
    logic [1:0] vend_item, change_coin;
    logic [6:0] credit;
    logic       d3_vend, d3_change_valid, d3_busy, d3_coin_reject, d3_sel_denied;
    logic [1:0] d3_vend_item, d3_change_coin;
    logic [6:0] d3_credit;

    pes_vm_multi dut (
        .clock(clock), .reset(reset), .coin(coin), .sel_valid(sel_valid), .sel(sel),
        .cancel(cancel), .vend(vend), .vend_item(vend_item), .change_valid(change_valid),
        .change_coin(change_coin), .credit(credit), .busy(busy),
        .coin_reject(coin_reject), .sel_denied(sel_denied)
    );

    pes_vm_multi #(.NUM_ITEMS(3), .PRICES({7'd30, 7'd20, 7'd15})) dut3 (
        .clock(clock), .reset(reset), .coin(d3_coin), .sel_valid(d3_sel_valid), .sel(d3_sel),
        .cancel(d3_cancel), .vend(d3_vend), .vend_item(d3_vend_item),
        .change_valid(d3_change_valid), .change_coin(d3_change_coin), .credit(d3_credit),
        .busy(d3_busy), .coin_reject(d3_coin_reject), .sel_denied(d3_sel_denied)
    );

    typedef struct packed {
        logic       vend;
        logic [1:0] item;
        logic       cv;
        logic [1:0] cc;
        logic [6:0] credit;
        logic       busy;
        logic       rej;
        logic       den;
    } obs_t;

    obs_t q0[$];
    obs_t q1[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic obs_t o(logic v, logic [1:0] it, logic cv, logic [1:0] cc,
                               int cr, logic b, logic rj, logic dn);
        return {v, it, cv, cc, 7'(cr), b, rj, dn};
    endfunction

    function automatic obs_t quiet(int cr);
        return o(1'b0, 2'd0, 1'b0, 2'd0, cr, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic obs_t chg(logic [1:0] cc, int cr, logic rj);
        return o(1'b0, 2'd0, 1'b1, cc, cr, 1'b1, rj, 1'b0);
    endfunction

    task automatic cmp(string tag, obs_t a, obs_t x);
        n_cmp++;
        if (a !== x) begin
            n_bad++;
            $display("FAIL %s: actual %h (credit %0d) required %h (credit %0d) at %0t",
                     tag, a, a.credit, x, x.credit, $time);
        end
    endtask

    // Monitor: compare whenever an output pulses or the output vector changes
    obs_t a0, a1, p0, p1;
    bit   first = 1'b1;
    always @(negedge clock) begin
        a0 = {vend, vend_item, change_valid, change_coin, credit, busy, coin_reject, sel_denied};
        a1 = {d3_vend, d3_vend_item, d3_change_valid, d3_change_coin, d3_credit, d3_busy,
              d3_coin_reject, d3_sel_denied};
        if (first || a0 !== p0 || a0.vend || a0.cv || a0.rej || a0.den) begin
            if (q0.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL main_unexpected: actual %h with no expected entry at %0t", a0, $time);
            end else begin
                cmp("main", a0, q0.pop_front());
            end
        end
        if (first || a1 !== p1 || a1.vend || a1.cv || a1.rej || a1.den) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL n3_unexpected: actual %h with no expected entry at %0t", a1, $time);
            end else begin
                cmp("n3", a1, q1.pop_front());
            end
        end
        p0    = a0;
        p1    = a1;
        first = 1'b0;
    end

    task automatic put(logic [1:0] c, logic sv, logic [1:0] s, logic cn);
        coin = c; sel_valid = sv; sel = s; cancel = cn;
        @(posedge clock); #1;
        coin = 2'd0; sel_valid = 1'b0; sel = 2'd0; cancel = 1'b0;
    endtask

    task automatic put3(logic [1:0] c, logic sv, logic [1:0] s, logic cn);
        d3_coin = c; d3_sel_valid = sv; d3_sel = s; d3_cancel = cn;
        @(posedge clock); #1;
        d3_coin = 2'd0; d3_sel_valid = 1'b0; d3_sel = 2'd0; d3_cancel = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        coin = 2'd0; sel_valid = 1'b0; sel = 2'd0; cancel = 1'b0;
        d3_coin = 2'd0; d3_sel_valid = 1'b0; d3_sel = 2'd0; d3_cancel = 1'b0;
        q0.push_back(quiet(0));
        q1.push_back(quiet(0));
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // exact payment: 5 + 10 for item 0 (15), no change
        q0.push_back(quiet(5));  put(2'd1, 1'b0, 2'd0, 1'b0);
        q0.push_back(quiet(15)); put(2'd2, 1'b0, 2'd0, 1'b0);
        q0.push_back(o(1'b1, 2'd0, 1'b0, 2'd0, 0, 1'b1, 1'b0, 1'b0));
        q0.push_back(quiet(0));
        put(2'd0, 1'b1, 2'd0, 1'b0); idle(1);

        // 25 for item 0: vend with 10 left, then one coin-2 change
        q0.push_back(quiet(25)); put(2'd3, 1'b0, 2'd0, 1'b0);
        q0.push_back(o(1'b1, 2'd0, 1'b0, 2'd0, 10, 1'b1, 1'b0, 1'b0));
        q0.push_back(chg(2'd2, 0, 1'b0));
        q0.push_back(quiet(0));
        put(2'd0, 1'b1, 2'd0, 1'b0); idle(2);

        // credit 10 too low for item 3 (50): denied, then refunded by cancel
        q0.push_back(quiet(10)); put(2'd2, 1'b0, 2'd0, 1'b0);
        q0.push_back(o(1'b0, 2'd0, 1'b0, 2'd0, 10, 1'b0, 1'b0, 1'b1));
        q0.push_back(quiet(10));
        put(2'd0, 1'b1, 2'd3, 1'b0); idle(1);
        q0.push_back(chg(2'd2, 0, 1'b0));
        q0.push_back(quiet(0));
        put(2'd0, 1'b0, 2'd0, 1'b1); idle(1);

        // cancel in IDLE still accepts its coin; cancel beats sel_valid in CREDIT
        q0.push_back(quiet(5)); put(2'd1, 1'b0, 2'd0, 1'b1);
        q0.push_back(chg(2'd1, 0, 1'b0));
        q0.push_back(quiet(0));
        put(2'd0, 1'b1, 2'd0, 1'b1); idle(1);

        // refund of 40 as 25,10,5 with a coin rejected mid-change
        q0.push_back(quiet(25)); put(2'd3, 1'b0, 2'd0, 1'b0);
        q0.push_back(quiet(35)); put(2'd2, 1'b0, 2'd0, 1'b0);
        q0.push_back(quiet(40)); put(2'd1, 1'b0, 2'd0, 1'b0);
        q0.push_back(chg(2'd3, 15, 1'b0)); put(2'd0, 1'b0, 2'd0, 1'b1);
        q0.push_back(chg(2'd2, 5, 1'b1));
        q0.push_back(chg(2'd1, 0, 1'b0));
        q0.push_back(quiet(0));
        put(2'd1, 1'b0, 2'd0, 1'b0); idle(2);

        // credit ceiling at 95
        q0.push_back(quiet(25)); put(2'd3, 1'b0, 2'd0, 1'b0);
        q0.push_back(quiet(50)); put(2'd3, 1'b0, 2'd0, 1'b0);
        q0.push_back(quiet(75)); put(2'd3, 1'b0, 2'd0, 1'b0);
        q0.push_back(quiet(85)); put(2'd2, 1'b0, 2'd0, 1'b0);
        q0.push_back(quiet(90)); put(2'd1, 1'b0, 2'd0, 1'b0);
        q0.push_back(o(1'b0, 2'd0, 1'b0, 2'd0, 90, 1'b0, 1'b1, 1'b0)); put(2'd2, 1'b0, 2'd0, 1'b0);
        q0.push_back(quiet(95)); put(2'd1, 1'b0, 2'd0, 1'b0);
        q0.push_back(o(1'b0, 2'd0, 1'b0, 2'd0, 95, 1'b0, 1'b1, 1'b0)); put(2'd1, 1'b0, 2'd0, 1'b0);
        q0.push_back(quiet(95)); idle(1);
        q0.push_back(chg(2'd3, 70, 1'b0));
        q0.push_back(chg(2'd3, 45, 1'b0));
        q0.push_back(chg(2'd3, 20, 1'b0));
        q0.push_back(chg(2'd2, 10, 1'b0));
        q0.push_back(chg(2'd2, 0, 1'b0));
        q0.push_back(quiet(0));
        put(2'd0, 1'b0, 2'd0, 1'b1); idle(6);

        // 45 for item 2 (30), reset lands during the first change cycle
        q0.push_back(quiet(25)); put(2'd3, 1'b0, 2'd0, 1'b0);
        q0.push_back(quiet(35)); put(2'd2, 1'b0, 2'd0, 1'b0);
        q0.push_back(quiet(45)); put(2'd2, 1'b0, 2'd0, 1'b0);
        q0.push_back(o(1'b1, 2'd2, 1'b0, 2'd0, 15, 1'b1, 1'b0, 1'b0));
        q0.push_back(chg(2'd2, 5, 1'b0));
        put(2'd0, 1'b1, 2'd2, 1'b0); idle(1);
        q0.push_back(quiet(0));
        reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;

        // same-cycle coin is accepted but does not fund the selection
        q0.push_back(quiet(10)); put(2'd2, 1'b0, 2'd0, 1'b0);
        q0.push_back(quiet(15)); put(2'd1, 1'b0, 2'd0, 1'b0);
        q0.push_back(o(1'b1, 2'd0, 1'b0, 2'd0, 5, 1'b1, 1'b0, 1'b0));
        q0.push_back(chg(2'd1, 0, 1'b0));
        q0.push_back(quiet(0));
        put(2'd1, 1'b1, 2'd0, 1'b0); idle(2);

        // 3-item build: index 3 is out of range even with ample credit
        q1.push_back(quiet(25)); put3(2'd3, 1'b0, 2'd0, 1'b0);
        q1.push_back(quiet(50)); put3(2'd3, 1'b0, 2'd0, 1'b0);
        q1.push_back(o(1'b0, 2'd0, 1'b0, 2'd0, 50, 1'b0, 1'b0, 1'b1));
        q1.push_back(quiet(50));
        put3(2'd0, 1'b1, 2'd3, 1'b0); idle(1);
        q1.push_back(o(1'b1, 2'd2, 1'b0, 2'd0, 20, 1'b1, 1'b0, 1'b0));
        q1.push_back(chg(2'd2, 10, 1'b0));
        q1.push_back(chg(2'd2, 0, 1'b0));
        q1.push_back(quiet(0));
        put3(2'd0, 1'b1, 2'd2, 1'b0); idle(3);

        idle(4);
        n_cmp++;
        if (q0.size() != 0) begin
            n_bad++;
            $display("FAIL main_drain: %0d expected responses never seen, required 0", q0.size());
        end
        n_cmp++;
        if (q1.size() != 0) begin
            n_bad++;
            $display("FAIL n3_drain: %0d expected responses never seen, required 0", q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
